// File: rtl/mips_fetch_queue.sv
// Fetch stage for the single-cycle MIPS core: issues imem reads, buffers {pc, word} pairs, flushes on redirect.
// Optional feature: define MIPS_FETCH_BYPASS_EN to forward a response straight to the core when the queue is empty.
module mips_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] lrd_q, lrd_d, lwr_q, lwr_d;

  logic [31:0] word_q [DEPTH];
  logic [31:0] pc_q   [DEPTH];
  logic [31:0] lpc_q  [DEPTH];

  logic [CW-1:0] live;
  logic [CW:0]   credit_used;
  logic          grant, rsp, keep, push, pop;

  assign live        = out_cnt_q - drop_cnt_q;
  assign credit_used = {1'b0, occ_q} + {1'b0, live};
  // Counting occ + live as spent credit means every kept response already owns a FIFO slot.
  assign imem_req    = reset_n && !redirect && (out_cnt_q < DEPTH_C) &&
                       (credit_used < {1'b0, DEPTH_C});
  assign imem_addr   = fetch_pc_q;
  assign grant       = imem_req && imem_gnt;
  assign rsp         = imem_rvalid && (out_cnt_q != '0);
  assign keep        = rsp && (drop_cnt_q == '0) && !redirect;

`ifdef MIPS_FETCH_BYPASS_EN
  logic bypass;
  assign bypass     = keep && (occ_q == '0);
  assign inst_valid = !redirect && ((occ_q != '0) || bypass);
  assign inst_data  = bypass ? imem_rdata   : word_q[rd_ptr_q];
  assign inst_pc    = bypass ? lpc_q[lrd_q] : pc_q[rd_ptr_q];
  assign push       = keep && !(bypass && inst_ready);
  assign pop        = inst_valid && inst_ready && !bypass;
`else
  assign inst_valid = !redirect && (occ_q != '0);
  assign inst_data  = word_q[rd_ptr_q];
  assign inst_pc    = pc_q[rd_ptr_q];
  assign push       = keep;
  assign pop        = inst_valid && inst_ready;
`endif

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    occ_d      = occ_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    lrd_d      = lrd_q;
    lwr_d      = lwr_q;
    if (redirect) begin
      // Everything still in flight becomes garbage, minus the response landing right now.
      fetch_pc_d = redirect_pc;
      occ_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      lrd_d      = '0;
      lwr_d      = '0;
      out_cnt_d  = out_cnt_q - CW'(rsp);
      drop_cnt_d = out_cnt_q - CW'(rsp);
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd1;
        lwr_d      = lwr_q + ONE_A;
      end
      out_cnt_d = out_cnt_q + CW'(grant) - CW'(rsp);
      if (rsp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - ONE_C;
      if (keep) lrd_d = lrd_q + ONE_A;
      if (push) wr_ptr_d = wr_ptr_q + ONE_A;
      if (pop)  rd_ptr_d = rd_ptr_q + ONE_A;
      occ_d = occ_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      occ_q      <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      lrd_q      <= '0;
      lwr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i]   <= '0;
        lpc_q[i]  <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      occ_q      <= occ_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      lrd_q      <= lrd_d;
      lwr_q      <= lwr_d;
      if (push) begin
        word_q[wr_ptr_q] <= imem_rdata;
        pc_q[wr_ptr_q]   <= lpc_q[lrd_q];
      end
      if (grant) lpc_q[lwr_q] <= fetch_pc_q;
    end
  end
endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue: in-order latency memory model plus a queue-based reference of the delivered stream.
// Expectations follow MIPS_FETCH_BYPASS_EN when it is defined for the build.
module tb_mips_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h100;
`ifdef MIPS_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  mips_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] pc;
    int          due;
    bit          stale;
  } mem_ent_t;

  typedef struct {
    bit          ready;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  mem_ent_t    mem_q [$];
  logic [31:0] q_pc [$];
  logic [31:0] m_fetch, m_stream;
  int          m_last_due;

  bit          s_redirect = 0, s_ready = 0, s_gnt = 0, s_stray = 0;
  logic [31:0] s_rpc = '0;
  int          s_lat = 1;

  bit          o_req, o_valid, o_rvalid, o_fire;
  logic [31:0] o_addr, o_pc, o_data, o_fire_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h2408_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: entered at a negedge, drives inputs, checks settled outputs, advances the model.
  task automatic step();
    mem_ent_t    e;
    bit          rsp_now, stale_now, had_q, consume, exp_req, exp_valid;
    int          live, due;
    logic [31:0] head_pc;
    rsp_now     = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    redirect    = s_redirect;
    redirect_pc = s_rpc;
    inst_ready  = s_ready;
    imem_gnt    = s_gnt;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (rsp_now) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].pc);
    end else if (s_stray) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      $display("cyc %0d  protocol: stray imem_rvalid with nothing outstanding", cyc);
    end
    #1;
    live = 0;
    foreach (mem_q[i]) if (!mem_q[i].stale) live++;
    exp_req   = !s_redirect && (mem_q.size() < DEPTH) && ((q_pc.size() + live) < DEPTH);
    stale_now = rsp_now && mem_q[0].stale;
    had_q     = q_pc.size() > 0;
    exp_valid = !s_redirect && (had_q || (BYP && rsp_now && !stale_now));
    head_pc   = had_q ? q_pc[0] : (rsp_now ? mem_q[0].pc : 32'h0);

    o_req = imem_req; o_addr = imem_addr; o_valid = inst_valid;
    o_pc = inst_pc; o_data = inst_data; o_rvalid = imem_rvalid;

    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_fetch);
    chk("inst_valid", inst_valid, exp_valid);
    if (exp_valid) begin
      chk("inst_pc", inst_pc, head_pc);
      chk("inst_data", inst_data, mem_word(head_pc));
    end
    consume   = exp_valid && s_ready;
    o_fire    = consume;
    o_fire_pc = inst_pc;
    if (consume) begin
      $display("cyc %0d  deliver pc=%08h data=%08h", cyc, inst_pc, inst_data);
      chk("stream_pc", inst_pc, m_stream);
      m_stream = m_stream + 32'd1;
    end

    if (rsp_now) e = mem_q.pop_front();
    if (s_redirect) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      q_pc.delete();
      m_fetch  = s_rpc;
      m_stream = s_rpc;
    end else begin
      if (consume && had_q) void'(q_pc.pop_front());
      if (rsp_now && !e.stale && !(BYP && !had_q && s_ready)) q_pc.push_back(e.pc);
      if (exp_req && s_gnt) begin
        due = (cyc + s_lat > m_last_due + 1) ? cyc + s_lat : m_last_due + 1;
        mem_q.push_back('{pc: m_fetch, due: due, stale: 1'b0});
        m_last_due = due;
        m_fetch    = m_fetch + 32'd1;
      end
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    #1;
    chk("rst_req", imem_req, 32'h0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", inst_valid, 32'h0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    mem_q.delete();
    q_pc.delete();
    m_fetch = RESET_PC;
    m_stream = RESET_PC;
    m_last_due = cyc;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic wait_fire(input string name, input logic [31:0] exp_pc);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (o_fire) begin
        found = 1'b1;
        chk(name, o_fire_pc, exp_pc);
      end
    end
    if (!found) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no instruction delivered within 40 cycles, required pc %08h", name, exp_pc);
    end
  endtask

  task automatic idle(input int n);
    s_redirect = 0; s_gnt = 0; s_ready = 1;
    repeat (n) step();
  endtask

  initial begin
    vec_t vecs [6];
    int   first_lat, ri, vi, fires;

    for (int i = 0; i < 6; i++) begin
      vecs[i].ready     = 1'b1;
      vecs[i].exp_req   = 1'b1;
      vecs[i].exp_addr  = RESET_PC + 32'(i);
      first_lat         = BYP ? 1 : 2;
      vecs[i].exp_valid = (i >= first_lat);
      vecs[i].exp_pc    = RESET_PC + 32'(i - first_lat);
    end

    @(negedge clock);
    do_reset();

    // Streaming from reset with a 1-cycle memory.
    s_gnt = 1; s_lat = 1;
    for (int i = 0; i < 6; i++) begin
      s_ready = vecs[i].ready;
      step();
      chk("vec_req", o_req, vecs[i].exp_req);
      chk("vec_addr", o_addr, vecs[i].exp_addr);
      chk("vec_valid", o_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) chk("vec_pc", o_pc, vecs[i].exp_pc);
    end

    // Backpressure: credits run out, nothing lost on release.
    s_ready = 0;
    repeat (10) step();
    chk("bp_req", o_req, 32'h0);
    chk("bp_valid", o_valid, 32'h1);
    s_ready = 1;
    repeat (10) step();

    // Redirect with three reads in flight.
    idle(10);
    s_gnt = 1; s_lat = 5;
    repeat (3) step();
    s_redirect = 1; s_rpc = 32'h200;
    step();
    chk("redir_valid", o_valid, 32'h0);
    chk("redir_req", o_req, 32'h0);
    s_redirect = 0; s_lat = 1;
    wait_fire("redir_first_pc", 32'h200);

    // Redirect landing on a response and a pop.
    s_lat = 2;
    repeat (8) step();
    s_redirect = 1; s_rpc = 32'h300;
    step();
    chk("flush_rvalid_seen", o_rvalid, 32'h1);
    s_redirect = 0;
    step();
    chk("flush_valid_next", o_valid, 32'h0);
    wait_fire("flush_first_pc", 32'h300);

    // Sustained throughput at latency 2.
    repeat (4) step();
    fires = 0;
    repeat (16) begin
      step();
      if (o_fire) fires++;
    end
    chk("throughput", 32'(fires), 32'd16);

    // Wrap across the top of the address space.
    s_redirect = 1; s_rpc = 32'hFFFF_FFFE; s_lat = 1;
    step();
    s_redirect = 0;
    wait_fire("wrap0", 32'hFFFF_FFFE);
    wait_fire("wrap1", 32'hFFFF_FFFF);
    wait_fire("wrap2", 32'h0000_0000);
    wait_fire("wrap3", 32'h0000_0001);

    // Stray response on an idle queue must be ignored, then latency check.
    idle(10);
    s_stray = 1;
    step();
    s_stray = 0;
    step();
    chk("stray_valid", o_valid, 32'h0);
    chk("stray_req", o_req, 32'h1);
    s_gnt = 1; s_lat = 1;
    step();
    s_gnt = 0;
    ri = -100; vi = -50;
    for (int k = 0; k < 10; k++) begin
      step();
      if (o_rvalid && ri < 0) ri = k;
      if (o_valid && vi < 0) vi = k;
    end
    chk("rsp_to_valid_latency", 32'(vi - ri), BYP ? 32'd0 : 32'd1);

    // Reset in the middle of traffic.
    s_gnt = 1; s_lat = 3; s_ready = 1;
    repeat (5) step();
    do_reset();
    wait_fire("post_reset_pc", RESET_PC);

    // Randomised traffic with occasional redirects.
    repeat (500) begin
      s_gnt      = ($urandom_range(0, 3) != 0);
      s_ready    = ($urandom_range(0, 3) != 0);
      s_lat      = $urandom_range(1, 6);
      s_redirect = ($urandom_range(0, 39) == 0);
      s_rpc      = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
